// File: rtl/instr_dcd_pkg.sv
// Shared definitions for the SPI instruction decoder and the register file
// behind it: bus widths, setup-byte field positions and FSM state codes.
package instr_dcd_pkg;

  // Default bus widths, shared with the register file
  localparam int ADDR_W = 6;
  localparam int DATA_W = 8;

  // Setup-byte fields: bit7 selects write (1) or read (0), bit6 is reserved
  localparam int RW_BIT   = 7;
  localparam int ADDR_LSB = 0;
  localparam int ADDR_MSB = 5;

  // FSM state codes
  typedef logic [2:0] state_t;
  localparam state_t ST_SETUP         = 3'd0;
  localparam state_t ST_WAIT_DATA     = 3'd1;
  localparam state_t ST_RD_ISSUE      = 3'd2;
  localparam state_t ST_RD_CAPTURE    = 3'd3;
  localparam state_t ST_RD_WAIT_DUMMY = 3'd4;

  // True when a setup byte requests a register write
  function automatic logic setup_is_write(input logic [DATA_W-1:0] b);
    return b[RW_BIT];
  endfunction

endpackage

// File: rtl/instr_dcd.sv
// SPI-side instruction decoder. Turns the byte stream from the SPI bridge
// into single-cycle register read/write strobes and captures the register
// file's read data into data_out for the bridge to shift back to the host.
//
// Handshake: byte_sync is a one-cycle valid strobe with no ready; a byte that
// arrives while a read is in flight is dropped and reported on overrun.
// cs_n = 1 closes the frame: the FSM returns to SETUP, byte_sync is ignored,
// and no new strobe is produced, though a strobe already registered for the
// current cycle still completes.
module instr_dcd #(
  parameter int ADDR_W = instr_dcd_pkg::ADDR_W,
  parameter int DATA_W = instr_dcd_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cs_n,
  input  logic              byte_sync,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              read,
  output logic              write,
  output logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_read,
  output logic [DATA_W-1:0] data_write,
  output logic              overrun,
  output logic [2:0]        state_dbg
);

  import instr_dcd_pkg::*;

  logic [2:0]        r_state;
  logic              r_read;
  logic              r_write;
  logic              r_overrun;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data_write;
  logic [DATA_W-1:0] r_data_out;

  logic [2:0]        w_state_nxt;
  logic              w_setup;     // setup byte accepted (address latched)
  logic              w_setup_rd;  // setup byte requests a read
  logic              w_data_wr;   // write data byte accepted
  logic              w_capture;   // register file data valid this cycle
  logic              w_drop;      // byte arrived while a read is in flight

  // Next-state decode and per-cycle events; cs_n overrides everything
  always_comb begin
    w_state_nxt = r_state;
    w_setup     = 1'b0;
    w_setup_rd  = 1'b0;
    w_data_wr   = 1'b0;
    w_capture   = 1'b0;
    w_drop      = 1'b0;
    if (cs_n) begin
      w_state_nxt = ST_SETUP;
    end else begin
      case (r_state)
        ST_SETUP: begin
          if (byte_sync) begin
            w_setup = 1'b1;
            if (setup_is_write(data_in)) begin
              w_state_nxt = ST_WAIT_DATA;
            end else begin
              w_setup_rd  = 1'b1;
              w_state_nxt = ST_RD_ISSUE;
            end
          end
        end
        ST_WAIT_DATA: begin
          if (byte_sync) begin
            w_data_wr   = 1'b1;
            w_state_nxt = ST_SETUP;
          end
        end
        ST_RD_ISSUE: begin
          w_drop      = byte_sync;
          w_state_nxt = ST_RD_CAPTURE;
        end
        ST_RD_CAPTURE: begin
          w_drop      = byte_sync;
          w_capture   = 1'b1;
          w_state_nxt = ST_RD_WAIT_DUMMY;
        end
        ST_RD_WAIT_DUMMY: begin
          // The dummy byte only paces the host's read; its value is discarded
          if (byte_sync) begin
            w_state_nxt = ST_SETUP;
          end
        end
        default: begin
          w_state_nxt = ST_SETUP;
        end
      endcase
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_SETUP;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Single-cycle strobes: cleared every cycle unless an event re-arms them
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_read    <= 1'b0;
      r_write   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_read    <= w_setup_rd;
      r_write   <= w_data_wr;
      r_overrun <= w_drop;
    end
  end

  // Register address, held between transactions
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr <= '0;
    end else if (w_setup) begin
      r_addr <= data_in[ADDR_LSB +: ADDR_W];
    end
  end

  // Write data, updated only when a write strobe is issued
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data_write <= '0;
    end else if (w_data_wr) begin
      r_data_write <= data_in;
    end
  end

  // Transmit byte: read data on capture, cleared when a write completes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data_out <= '0;
    end else if (w_capture) begin
      r_data_out <= data_read;
    end else if (w_data_wr) begin
      r_data_out <= '0;
    end
  end

  assign read       = r_read;
  assign write      = r_write;
  assign overrun    = r_overrun;
  assign addr       = r_addr;
  assign data_write = r_data_write;
  assign data_out   = r_data_out;
  assign state_dbg  = r_state;

endmodule

// File: tb/tb_instr_dcd.sv
// Directed bench for instr_dcd with a cycle-stamped transaction model and
// a small register file that answers read strobes one cycle later.
module tb_instr_dcd;

  import instr_dcd_pkg::*;

  localparam int AW = 6;
  localparam int DW = 8;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cs_n = 1'b0;
  logic          byte_sync = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic [DW-1:0] data_read = '0;
  logic [DW-1:0] data_out;
  logic [DW-1:0] data_write;
  logic          read;
  logic          write;
  logic          overrun;
  logic [AW-1:0] addr;
  logic [2:0]    state_dbg;

  always #5 clk = ~clk;

  instr_dcd #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .cs_n       (cs_n),
    .byte_sync  (byte_sync),
    .data_in    (data_in),
    .data_out   (data_out),
    .read       (read),
    .write      (write),
    .addr       (addr),
    .data_read  (data_read),
    .data_write (data_write),
    .overrun    (overrun),
    .state_dbg  (state_dbg)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- register file environment ----------------
  logic [DW-1:0] rf [64];
  always @(posedge clk) begin
    if (read)  data_read <= rf[addr];
    if (write) rf[addr]  <= data_write;
  end

  // ---------------- transaction model ----------------
  // Each accepted byte schedules its effects by cycle number: a read setup at
  // cycle c shows read at c+1, is in flight through c+2 and lands in data_out
  // from c+3; a write data byte shows write and clears data_out at c+1.
  logic [DW-1:0] m_regs [64];
  int            cyc = 0;
  int            cap_at = -1;
  bit            wait_data = 1'b0;
  bit            wait_dummy = 1'b0;
  logic          e_read = 1'b0, e_write = 1'b0, e_ovr = 1'b0;
  logic [AW-1:0] e_addr = '0;
  logic [DW-1:0] e_dw = '0, e_dout = '0;

  always @(posedge clk) begin
    cyc++;
    e_read  = 1'b0;
    e_write = 1'b0;
    e_ovr   = 1'b0;
    if (rst) begin
      e_addr = '0; e_dw = '0; e_dout = '0;
      cap_at = -1; wait_data = 1'b0; wait_dummy = 1'b0;
    end else if (cs_n) begin
      cap_at = -1; wait_data = 1'b0; wait_dummy = 1'b0;
    end else begin
      if (byte_sync) begin
        if (cap_at != -1) begin
          e_ovr = 1'b1;
        end else if (wait_data) begin
          e_write = 1'b1;
          e_dw    = data_in;
          e_dout  = '0;
          m_regs[e_addr] = data_in;
          wait_data = 1'b0;
        end else if (wait_dummy) begin
          wait_dummy = 1'b0;
        end else begin
          e_addr = data_in[5:0];
          if (data_in[7]) begin
            wait_data = 1'b1;
          end else begin
            e_read = 1'b1;
            cap_at = cyc + 2;
          end
        end
      end
      if (cap_at == cyc) begin
        e_dout     = m_regs[e_addr];
        cap_at     = -1;
        wait_dummy = 1'b1;
      end
    end
  end

  // ---------------- scoreboard compare + strobe monitor ----------------
  logic p_read = 1'b0, p_write = 1'b0;
  int   cnt_rd = 0, cnt_wr = 0, cnt_ovr = 0;

  always @(negedge clk) begin
    if (!rst) begin
      chk("read", read, e_read);
      chk("write", write, e_write);
      chk("overrun", overrun, e_ovr);
      chk("addr", addr, e_addr);
      chk("data_write", data_write, e_dw);
      chk("data_out", data_out, e_dout);
      chk("rw_exclusive", read & write, 0);
      chk("read_twice", read & p_read, 0);
      chk("write_twice", write & p_write, 0);
      cnt_rd  += int'(read);
      cnt_wr  += int'(write);
      cnt_ovr += int'(overrun);
    end
    p_read  = read;
    p_write = write;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send(input logic [DW-1:0] b);
    byte_sync = 1'b1;
    data_in   = b;
    tick();
    byte_sync = 1'b0;
    data_in   = DW'($urandom_range(0, 255));
  endtask

  int rd0, wr0, ov0;

  // ---------------- directed sequences ----------------
  initial begin
    for (int i = 0; i < 64; i++) begin
      rf[i]     = DW'(i) ^ 8'hA5;
      m_regs[i] = DW'(i) ^ 8'hA5;
    end
    rf[8]  = 8'h34; m_regs[8]  = 8'h34;
    rf[10] = 8'hC3; m_regs[10] = 8'hC3;
    rf[2]  = 8'h77; m_regs[2]  = 8'h77;

    // Power-on reset
    idle(3);
    chk("por_outputs", {read, write, overrun, addr, data_write, data_out}, 0);
    chk("por_state", state_dbg, ST_SETUP);
    rst = 1'b0;
    idle(2);

    // Write: 0x83 then 0x5A
    rd0 = cnt_rd; wr0 = cnt_wr;
    send(8'h83);
    idle(2);
    send(8'h5A);
    chk("wr_pulse", write, 1);
    chk("wr_addr", addr, 8'h03);
    chk("wr_data", data_write, 8'h5A);
    tick();
    chk("wr_pulse_end", write, 0);
    idle(2);
    chk("wr_count", cnt_wr - wr0, 1);
    chk("wr_no_read", cnt_rd - rd0, 0);

    // Read: 0x08, register holds 0x34
    send(8'h08);
    chk("rd_pulse", read, 1);
    chk("rd_addr", addr, 8'h08);
    tick();
    chk("rd_pulse_end", read, 0);
    tick();
    chk("rd_data_out", data_out, 8'h34);
    idle(2);
    chk("rd_wait_dummy", state_dbg, ST_RD_WAIT_DUMMY);
    send(8'hAA);
    chk("rd_back_setup", state_dbg, ST_SETUP);
    chk("rd_data_held", data_out, 8'h34);

    // Abort: write setup 0x81, cs_n high for 2 cycles with 0xFF ignored
    wr0 = cnt_wr;
    send(8'h81);
    cs_n = 1'b1;
    send(8'hFF);
    tick();
    chk("abort_state", state_dbg, ST_SETUP);
    chk("abort_addr_kept", addr, 8'h01);
    cs_n = 1'b0;
    send(8'h02);
    chk("abort_next_read", read, 1);
    chk("abort_next_addr", addr, 8'h02);
    idle(3);
    chk("abort_data_out", data_out, 8'h77);
    chk("abort_no_write", cnt_wr - wr0, 0);
    send(8'h00);

    // Overrun: 0x0A followed by a byte one cycle later
    ov0 = cnt_ovr;
    send(8'h0A);
    send(8'h55);
    chk("ovr_pulse", overrun, 1);
    tick();
    chk("ovr_pulse_end", overrun, 0);
    chk("ovr_data_out", data_out, 8'hC3);
    send(8'h00);
    chk("ovr_back_setup", state_dbg, ST_SETUP);
    idle(1);
    chk("ovr_count", cnt_ovr - ov0, 1);

    // Back-to-back: write 0x8C/0x01 immediately followed by read 0x0C
    rd0 = cnt_rd; wr0 = cnt_wr;
    send(8'h8C);
    send(8'h01);
    chk("b2b_write", write, 1);
    chk("b2b_dout_clear", data_out, 8'h00);
    send(8'h0C);
    chk("b2b_read", read, 1);
    chk("b2b_write_end", write, 0);
    idle(2);
    chk("b2b_data_out", data_out, 8'h01);
    send(8'h00);
    idle(1);
    chk("b2b_rd_count", cnt_rd - rd0, 1);
    chk("b2b_wr_count", cnt_wr - wr0, 1);

    // Reset mid-frame: write setup pending, rst held 3 cycles
    rd0 = cnt_rd; wr0 = cnt_wr;
    send(8'h81);
    rst = 1'b1;
    #1;
    chk("mid_rst_outputs", {read, write, overrun, addr, data_write, data_out}, 0);
    chk("mid_rst_state", state_dbg, ST_SETUP);
    idle(3);
    rst = 1'b0;
    idle(4);
    chk("mid_rst_no_write", cnt_wr - wr0, 0);
    chk("mid_rst_no_read", cnt_rd - rd0, 0);
    chk("mid_rst_state_after", state_dbg, ST_SETUP);

    idle(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_dcd.md
Name: instr_dcd

Overview:
- SPI-side instruction decoder sitting directly upstream of the register file.
- Turns a byte stream from the SPI bridge into single-cycle register read/write strobes (`read`, `write`, `addr`, `data_write`).
- Captures the register file's registered `data_read` into `data_out`, which the bridge shifts back to the host.
- Transaction format: setup byte, then one data byte (write) or one dummy byte (read).

Parameters:
- ADDR_W, 6, register address width.
- DATA_W, 8, byte width.

Ports:
- clk  input  1  peripheral clock
- rst  input  1  asynchronous, active-high reset
- cs_n  input  1  frame select from SPI bridge, already synchronised to clk; 1 = no frame / abort
- byte_sync  input  1  one-cycle strobe: data_in holds a complete received byte
- data_in  input  DATA_W  received byte
- data_out  output  DATA_W  byte to transmit on the next SPI byte
- read  output  1  one-cycle register read strobe
- write  output  1  one-cycle register write strobe
- addr  output  ADDR_W  register address, held stable between transactions
- data_read  input  DATA_W  register file read data, valid one cycle after the read strobe
- data_write  output  DATA_W  write data, valid while write = 1
- overrun  output  1  one-cycle pulse when a byte is dropped

Behaviour:
- Reset (async, rst = 1): state SETUP; outputs data_out, read, write, addr, data_write, overrun all 0.
- All outputs are registered.
- Setup byte encoding:
  - bit7: 1 = write, 0 = read
  - bit6: reserved, ignored
  - bits[5:0]: addr
- States: SETUP, WAIT_DATA, RD_ISSUE, RD_CAPTURE, RD_WAIT_DUMMY.
- SETUP:
  - On byte_sync at cycle T: addr <= data_in[5:0] (visible from T+1).
  - If bit7 = 1 -> WAIT_DATA.
  - If bit7 = 0 -> RD_ISSUE, and read = 1 during cycle T+1 only.
- RD_ISSUE: read = 1 this cycle -> RD_CAPTURE.
- RD_CAPTURE (T+2): data_out <= data_read (visible from T+3) -> RD_WAIT_DUMMY.
- RD_WAIT_DUMMY: on byte_sync, the dummy byte is discarded -> SETUP. data_out holds its value until the next read capture.
- WAIT_DATA: on byte_sync at cycle T2:
  - data_write <= data_in, write = 1 during T2+1 only, addr unchanged.
  - -> SETUP.
  - data_out <= 0x00 at T2+1.
- Back-to-back frames: a byte_sync in SETUP during the cycle write = 1 starts the next transaction normally.
- byte_sync in RD_ISSUE or RD_CAPTURE: byte dropped, overrun pulses 1 cycle, read sequence completes, then RD_WAIT_DUMMY.
- cs_n = 1 in any state:
  - Next state SETUP; byte_sync is ignored.
  - A pending write is not issued; no read or write strobe is generated after the cs_n sample.
  - A strobe already registered for the current cycle completes its single cycle.
  - addr, data_write and data_out keep their values.
- read and write are mutually exclusive and never high for two consecutive cycles from one transaction.
- Reset asserted mid-transaction: immediate return to reset values; no strobe on reset release.

Decomposition:
- Shared package holds:
  - setup-byte field constants: RW_BIT = 7, ADDR_LSB = 0, ADDR_MSB = 5
  - state enum/localparams: SETUP, WAIT_DATA, RD_ISSUE, RD_CAPTURE, RD_WAIT_DUMMY
  - ADDR_W and DATA_W defaults, shared with the register file
- No sub-module: a single FSM plus output registers.

Test Plan:
- Reset: hold rst = 1 for 3 cycles mid-frame -> all outputs 0, state SETUP; no strobe after release.
- Write: byte 0x83, then byte 0x5A -> single write pulse 1 cycle after the second byte_sync, addr = 0x03, data_write = 0x5A; read never asserted.
- Read: byte 0x08 with register model returning 0x34 one cycle after read -> read pulse at T+1 with addr = 0x08; data_out = 0x34 from T+3; dummy byte returns FSM to SETUP.
- Abort: byte 0x81, then cs_n = 1 for 2 cycles, then byte 0xFF -> no write pulse; a following 0x02 -> read pulse with addr = 0x02.
- Overrun: byte 0x0A, then another byte_sync exactly 1 cycle later -> overrun pulses once; read still completes; data_out = model value.
- Back-to-back: write 0x8C/0x01 immediately followed by read 0x0C -> write then read strobes, each exactly 1 cycle, never overlapping; data_out = 0x01.
